gps_stream_sched: RTL and testbench

- Schedules GPS sample transfers into the SPI bridge state machine.
- Captures 4-bit GPS samples (I0,I1,Q0,Q1) on a sample strobe into a small FIFO.
- Issues one DATAREADY per sample, spaced so the bridge always finishes its 4-bit burst first, and holds the sample bits stable for the bridge.
- Adds MCU run/stop control, frame-sync marking, and overflow accounting. Sits between the GPS front-end pins and the bridge.

---
 rtl/gps_stream_sched.sv | 158 +++++++++++++++
 tb/tb_gps_stream_sched.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/gps_stream_sched.sv
// Queues 4-bit GPS samples and issues one DATAREADY per sample to the SPI bridge, spaced SLOT_CYCLES apart.
// Strobe-to-DATAREADY is 2 cycles when idle; a full FIFO drops new samples (sticky OVERFLOW, saturating DROP_COUNT).
module gps_stream_sched #(
  parameter int DEPTH       = 4,
  parameter int SLOT_CYCLES = 6,
  parameter int FRAME_LEN   = 1023
) (
  input  logic                     MCU_CLK_25_000,
  input  logic                     RESET_N,
  input  logic                     GPS_I0,
  input  logic                     GPS_I1,
  input  logic                     GPS_Q0,
  input  logic                     GPS_Q1,
  input  logic                     GPS_STB,
  input  logic                     MCU_RUN,
  input  logic                     OVF_CLR,
  output logic                     DATAREADY,
  output logic                     SMP_I0,
  output logic                     SMP_I1,
  output logic                     SMP_Q0,
  output logic                     SMP_Q1,
  output logic                     FRAME_SYNC,
  output logic                     OVERFLOW,
  output logic [7:0]               DROP_COUNT,
  output logic [$clog2(DEPTH):0]   FIFO_LEVEL
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(SLOT_CYCLES);
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    READY = 3'd2,
    SLOT  = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic [SW-1:0] slot_cnt;
  logic [FW-1:0] frame_cnt;
  logic [3:0]    smp;
  logic [3:0]    smp_in;
  logic          fifo_empty, fifo_full, slot_end;
  logic          push_req, push_ok, pop, drop, flush;

  assign smp_in     = {GPS_I0, GPS_I1, GPS_Q0, GPS_Q1};
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == (AW+1)'(DEPTH));
  // The slot occupies SLOT_CYCLES-1 cycles in SLOT; the READY cycle completes the period.
  assign slot_end   = (slot_cnt <= SW'(1));
  assign {SMP_I0, SMP_I1, SMP_Q0, SMP_Q1} = smp;
  assign FIFO_LEVEL = level;

  always_comb begin
    state_nxt = state;
    push_req  = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;
    case (state)
      IDLE: begin
        flush = 1'b1;
        if (MCU_RUN) state_nxt = ARM;
      end
      ARM: begin
        if (!MCU_RUN) begin
          state_nxt = IDLE;
        end else if (GPS_STB) begin
          push_req  = 1'b1;
          state_nxt = READY;
        end
      end
      READY: begin
        push_req = GPS_STB;
        if (!MCU_RUN) begin
          state_nxt = STOP;
        end else if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = SLOT;
        end
      end
      SLOT: begin
        push_req = GPS_STB;
        if (slot_end) state_nxt = MCU_RUN ? READY : STOP;
      end
      STOP: begin
        flush     = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        flush     = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push_req & (~fifo_full | pop);
  assign drop    = push_req & fifo_full & ~pop;

  always_ff @(posedge MCU_CLK_25_000 or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      slot_cnt   <= '0;
      frame_cnt  <= '0;
      smp        <= '0;
      DATAREADY  <= 1'b0;
      FRAME_SYNC <= 1'b0;
      OVERFLOW   <= 1'b0;
      DROP_COUNT <= '0;
    end else begin
      state      <= state_nxt;
      DATAREADY  <= pop;
      FRAME_SYNC <= pop && (frame_cnt == '0);

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
        smp    <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
          smp    <= mem[rd_ptr];
        end
        if (push_ok && !pop)      level <= level + 1'b1;
        else if (!push_ok && pop) level <= level - 1'b1;
      end

      if (pop)                                   slot_cnt <= SW'(SLOT_CYCLES - 1);
      else if (state == SLOT && slot_cnt != '0)  slot_cnt <= slot_cnt - 1'b1;

      if (state == ARM) frame_cnt <= '0;
      else if (pop)     frame_cnt <= (frame_cnt == FW'(FRAME_LEN - 1)) ? '0 : frame_cnt + 1'b1;

      // A drop coinciding with a clear leaves exactly that one drop recorded.
      if (drop) begin
        OVERFLOW   <= 1'b1;
        DROP_COUNT <= OVF_CLR ? 8'd1 : ((DROP_COUNT == 8'hFF) ? 8'hFF : DROP_COUNT + 8'd1);
      end else if (OVF_CLR) begin
        OVERFLOW   <= 1'b0;
        DROP_COUNT <= '0;
      end
    end
  end

  always_ff @(posedge MCU_CLK_25_000) begin
    if (push_ok) mem[wr_ptr] <= smp_in;
  end

endmodule

// File: tb/tb_gps_stream_sched.sv
// Bench for gps_stream_sched: directed scenarios plus random traffic, compared each cycle to a queue-based model.
module tb_gps_stream_sched;
  localparam int DEPTH       = 4;
  localparam int SLOT_CYCLES = 6;
  localparam int FRAME_LEN   = 3;

  logic MCU_CLK_25_000 = 1'b0;
  logic RESET_N, GPS_I0, GPS_I1, GPS_Q0, GPS_Q1, GPS_STB, MCU_RUN, OVF_CLR;
  logic DATAREADY, SMP_I0, SMP_I1, SMP_Q0, SMP_Q1, FRAME_SYNC, OVERFLOW;
  logic [7:0] DROP_COUNT;
  logic [$clog2(DEPTH):0] FIFO_LEVEL;
  logic [3:0] smp_obs;

  always #5 MCU_CLK_25_000 = ~MCU_CLK_25_000;
  assign smp_obs = {SMP_I0, SMP_I1, SMP_Q0, SMP_Q1};

  gps_stream_sched #(.DEPTH(DEPTH), .SLOT_CYCLES(SLOT_CYCLES), .FRAME_LEN(FRAME_LEN)) dut (
    .MCU_CLK_25_000(MCU_CLK_25_000), .RESET_N(RESET_N),
    .GPS_I0(GPS_I0), .GPS_I1(GPS_I1), .GPS_Q0(GPS_Q0), .GPS_Q1(GPS_Q1),
    .GPS_STB(GPS_STB), .MCU_RUN(MCU_RUN), .OVF_CLR(OVF_CLR),
    .DATAREADY(DATAREADY), .SMP_I0(SMP_I0), .SMP_I1(SMP_I1), .SMP_Q0(SMP_Q0), .SMP_Q1(SMP_Q1),
    .FRAME_SYNC(FRAME_SYNC), .OVERFLOW(OVERFLOW), .DROP_COUNT(DROP_COUNT), .FIFO_LEVEL(FIFO_LEVEL)
  );

  int total = 0, bad = 0, cyc = 0;
  // Model: 0 off, 1 armed (waiting for first sample), 2 streaming, 3 stopping.
  int m_phase, m_last, m_frame, m_drops;
  bit m_ovf;
  logic [3:0] m_q[$];
  bit e_dr, e_fs;
  logic [3:0] e_smp;
  int dr_q[$];
  bit fs_q[$];
  bit run_r;
  int seq;
  bit p;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s @cycle %0d: got %0h want %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_last = -100; m_frame = 0; m_drops = 0; m_ovf = 0;
    m_q.delete(); e_dr = 0; e_fs = 0; e_smp = '0;
  endtask

  function automatic bit will_pop();
    return m_phase == 2 && m_q.size() > 0 && cyc >= m_last + SLOT_CYCLES - 1;
  endfunction

  // Advances the model over the clock edge that ends cycle cyc.
  task automatic model_step(input bit stb, input bit run, input bit clr, input logic [3:0] s);
    bit push, pop, drop, clear_q;
    push = 0; pop = 0; drop = 0; e_dr = 0; e_fs = 0;
    clear_q = (m_phase == 0 || m_phase == 3);
    case (m_phase)
      0: if (run) begin m_phase = 1; m_frame = 0; end
      1: begin
        if (!run) m_phase = 0;
        else if (stb) begin push = 1; m_phase = 2; end
      end
      2: begin
        push = stb;
        if (!run && cyc >= m_last + SLOT_CYCLES - 2) m_phase = 3;
        else if (run && m_q.size() > 0 && cyc >= m_last + SLOT_CYCLES - 1) pop = 1;
      end
      default: m_phase = 0;
    endcase
    if (pop) begin
      e_smp = m_q.pop_front(); e_dr = 1; e_fs = (m_frame == 0);
      m_frame = (m_frame + 1) % FRAME_LEN; m_last = cyc + 1;
    end
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(s);
      else drop = 1;
    end
    if (drop) begin
      m_ovf = 1;
      m_drops = clr ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
    end else if (clr) begin
      m_ovf = 0; m_drops = 0;
    end
    if (clear_q) begin m_q.delete(); e_smp = '0; end
  endtask

  task automatic check_outputs();
    check("dataready", DATAREADY, e_dr);
    check("frame_sync", FRAME_SYNC, e_fs);
    check("smp", smp_obs, e_smp);
    check("fifo_level", FIFO_LEVEL, m_q.size());
    check("overflow", OVERFLOW, m_ovf);
    check("drop_count", DROP_COUNT, m_drops);
    if (DATAREADY === 1'b1) begin dr_q.push_back(cyc); fs_q.push_back(FRAME_SYNC); end
  endtask

  task automatic tick(input bit stb, input bit run, input bit clr, input logic [3:0] s);
    GPS_STB = stb; {GPS_I0, GPS_I1, GPS_Q0, GPS_Q1} = s; MCU_RUN = run; OVF_CLR = clr;
    model_step(stb, run, clr, s);
    @(negedge MCU_CLK_25_000);
    cyc++;
    check_outputs();
  endtask

  initial begin
    RESET_N = 0; GPS_STB = 0; {GPS_I0, GPS_I1, GPS_Q0, GPS_Q1} = '0; MCU_RUN = 0; OVF_CLR = 0;
    model_reset();
    repeat (2) @(negedge MCU_CLK_25_000);
    check_outputs();
    RESET_N = 1; cyc = 0;

    // Single sample at cycle 10.
    for (int c = 0; c < 10; c++) tick(0, 1, 0, 4'h0);
    tick(1, 1, 0, 4'b1011);
    check("lvl_c11", FIFO_LEVEL, 1);
    tick(0, 1, 0, 4'h0);
    check("dr_c12", DATAREADY, 1);
    check("fs_c12", FRAME_SYNC, 1);
    for (int k = 0; k < 6; k++) begin
      check("smp_hold", smp_obs, 4'b1011);
      if (k < 5) tick(0, 1, 0, 4'h0);
    end

    // Strobe every cycle for 20 cycles.
    repeat (4) tick(0, 1, 0, 4'h0);
    dr_q.delete(); fs_q.delete();
    for (int i = 0; i < 20; i++) tick(1, 1, 0, 4'(i));
    check("burst_ovf", OVERFLOW, 1);
    check("burst_lvl", FIFO_LEVEL, DEPTH);
    check("burst_drops", DROP_COUNT, 12);
    check("burst_dr_cnt", dr_q.size(), 4);
    for (int i = 1; i < dr_q.size(); i++) check("dr_spacing", dr_q[i] - dr_q[i-1], SLOT_CYCLES);
    tick(will_pop(), 1, 1, 4'h0);
    check("clr_ovf", OVERFLOW, 0);
    check("clr_drops", DROP_COUNT, 0);

    // Full FIFO: push only when a pop happens.
    seq = 20;
    for (int i = 0; i < 40; i++) begin
      p = will_pop();
      tick(p, 1, 0, 4'(seq));
      if (p) seq++;
    end
    check("full_lvl", FIFO_LEVEL, DEPTH);
    check("full_ovf", OVERFLOW, 0);

    // Random traffic.
    run_r = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) run_r = ~run_r;
      tick($urandom_range(0, 3) == 0, run_r, $urandom_range(0, 29) == 0, 4'($urandom));
    end

    // MCU_RUN falls mid-slot with two samples queued.
    repeat (8) tick(0, 0, 0, 4'h0);
    tick(0, 1, 0, 4'h0);
    tick(1, 1, 0, 4'h1); tick(1, 1, 0, 4'h2); tick(1, 1, 0, 4'h3);
    check("stop_lvl_before", FIFO_LEVEL, 2);
    dr_q.delete();
    for (int i = 0; i < 10; i++) tick(0, 0, 0, 4'h0);
    check("stop_no_dr", dr_q.size(), 0);
    check("stop_lvl", FIFO_LEVEL, 0);

    // Restart: seven samples, frame sync on 1st, 4th, 7th.
    dr_q.delete(); fs_q.delete();
    for (int i = 0; i < 50; i++) tick(i % 6 == 0 && i > 0 && i <= 42, 1, 0, 4'(i));
    check("frame_dr_cnt", fs_q.size(), 7);
    for (int k = 0; k < fs_q.size(); k++) check("frame_sync_idx", fs_q[k], (k % 3) == 0);

    // Asynchronous reset right on a DATAREADY.
    for (int i = 0; i < 30 && !(DATAREADY === 1'b1 && FIFO_LEVEL != 0); i++) tick(i % 2 == 0, 1, 0, 4'hF);
    check("pre_rst_dr", DATAREADY, 1);
    #2 RESET_N = 0;
    #1;
    check("rst_dr", DATAREADY, 0);
    check("rst_smp", smp_obs, 0);
    check("rst_fs", FRAME_SYNC, 0);
    check("rst_lvl", FIFO_LEVEL, 0);
    check("rst_ovf", OVERFLOW, 0);
    check("rst_drops", DROP_COUNT, 0);
    model_reset();
    @(negedge MCU_CLK_25_000);
    cyc++;
    RESET_N = 1;
    check_outputs();
    dr_q.delete();
    for (int i = 0; i < 10; i++) tick(i % 3 == 0, 0, 0, 4'h5);
    for (int i = 0; i < 10; i++) tick(0, 1, 0, 4'h0);
    check("post_rst_no_dr", dr_q.size(), 0);
    tick(1, 1, 0, 4'h9);
    repeat (8) tick(0, 1, 0, 4'h0);
    check("post_rst_dr", dr_q.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
